// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - trace entry widths, field offsets, entry struct and packing helper (TRACE_TIMESTAMP_EN adds a 32-bit timestamp field)
package trace_pkg;

  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_ADDR_W = 9;

`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif

  // Entry without the optional timestamp; the timestamp, when present, sits above it.
  localparam int BASE_W  = 1 + 5 + TRACE_DATA_W + 1 + 1 + TRACE_ADDR_W + TRACE_DATA_W;
  localparam int ENTRY_W = TS_W + BASE_W;

  localparam int MEM_DATA_LSB = 0;
  localparam int ADDR_LSB     = MEM_DATA_LSB + TRACE_DATA_W;
  localparam int MEM_RD_BIT   = ADDR_LSB + TRACE_ADDR_W;
  localparam int MEM_WR_BIT   = MEM_RD_BIT + 1;
  localparam int REG_DATA_LSB = MEM_WR_BIT + 1;
  localparam int REG_NUM_LSB  = REG_DATA_LSB + TRACE_DATA_W;
  localparam int REG_EV_BIT   = REG_NUM_LSB + 5;
  localparam int TS_LSB       = BASE_W;

  typedef struct packed {
    logic                    reg_ev;
    logic [4:0]              reg_num;
    logic [TRACE_DATA_W-1:0] reg_data;
    logic                    mem_wr;
    logic                    mem_rd;
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] mem_data;
  } trace_base_t;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
    trace_base_t     base;
  } trace_entry_t;

  // Builds the commit fields; fields belonging to an absent event stay zero.
  function automatic trace_base_t pack_entry(
    input logic                    reg_write_sig,
    input logic [4:0]              reg_num,
    input logic [TRACE_DATA_W-1:0] reg_data,
    input logic                    wr,
    input logic                    rd,
    input logic [TRACE_ADDR_W-1:0] addr,
    input logic [TRACE_DATA_W-1:0] wr_data,
    input logic [TRACE_DATA_W-1:0] rd_data
  );
    trace_base_t e;
    logic        reg_ev;
    reg_ev   = reg_write_sig && (reg_num != 5'd0);
    e        = '0;
    e.reg_ev = reg_ev;
    if (reg_ev) begin
      e.reg_num  = reg_num;
      e.reg_data = reg_data;
    end
    e.mem_wr = wr;
    e.mem_rd = rd;
    if (wr || rd) e.addr = addr;
    // A store wins the data field when both strobes are high.
    if (wr) e.mem_data = wr_data;
    else if (rd) e.mem_data = rd_data;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - DEPTH x WIDTH synchronous FIFO with registered head output and occupancy level
module trace_fifo #(
  parameter  int WIDTH = 81,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] head;

  assign empty      = (count_q == '0);
  assign full       = (count_q == LVL_W'(DEPTH));
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign level      = count_q;

  // Next-state pointers/occupancy and the value the head register must show after this edge.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) count_d = count_q + LVL_W'(1);
    else if (!push_ok && pop_ok) count_d = count_q - LVL_W'(1);
    // The new head may be the entry being written on this very edge.
    head    = (push_ok && (wr_ptr_q == rd_ptr_d)) ? din : mem[rd_ptr_d];
    valid_d = (count_d != '0);
    dout_d  = valid_d ? head : '0;
  end

  // Storage array write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  // Pointer, occupancy and head-register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - commit trace capture into a drop-counting FIFO (TRACE_TIMESTAMP_EN prepends a cycle timestamp)
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 9,
  parameter  int DEPTH   = 16,
  parameter  int DROP_W  = 16,
  localparam int BASE_L  = 1 + 5 + DATA_W + 1 + 1 + ADDR_W + DATA_W,
  localparam int ENTRY_L = TS_W + BASE_L,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trace_en,
  input  logic               reg_write_sig,
  input  logic [4:0]         reg_num,
  input  logic [DATA_W-1:0]  reg_data,
  input  logic               wr,
  input  logic               rd,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_L-1:0] out_entry,
  output logic [LVL_W-1:0]   level,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_cnt,
  input  logic               clear_ovf
);

  logic               reg_ev, mem_ev, event_v;
  logic [BASE_L-1:0]  base_w;
  logic [ENTRY_L-1:0] entry_w;
  logic               fifo_full, fifo_empty;
  logic               drop;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

  assign reg_ev  = reg_write_sig && (reg_num != 5'd0);
  assign mem_ev  = wr || rd;
  assign event_v = trace_en && (reg_ev || mem_ev);

  if (DATA_W == TRACE_DATA_W && ADDR_W == TRACE_ADDR_W) begin : g_pkg_pack
    assign base_w = pack_entry(reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data);
  end else begin : g_generic_pack
    assign base_w = {reg_ev,
                     reg_ev ? reg_num : 5'd0,
                     reg_ev ? reg_data : {DATA_W{1'b0}},
                     wr, rd,
                     mem_ev ? addr : {ADDR_W{1'b0}},
                     wr ? wr_data : (rd ? rd_data : {DATA_W{1'b0}})};
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running cycle counter sampled into each entry.
  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + TS_W'(1);
  end

  assign entry_w = {ts_q, base_w};
`else
  assign entry_w = base_w;
`endif

  trace_fifo #(
    .WIDTH (ENTRY_L),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (event_v),
    .pop        (out_ready),
    .din        (entry_w),
    .dout       (out_entry),
    .dout_valid (out_valid),
    .level      (level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // A push is lost only when full and the head is not leaving on the same edge.
  assign drop = event_v && fifo_full && !(out_ready && !fifo_empty);

  // Sticky overflow and saturating drop counter; a clear beats a coincident drop.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  // Overflow status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - randomized self-checking bench for commit_trace_buffer against a queue model
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, trace_en, reg_write_sig, wr, rd, out_ready, clear_ovf;
  logic [4:0]         reg_num;
  logic [31:0]        reg_data, wr_data, rd_data;
  logic [8:0]         addr;
  logic               out_valid, overflow;
  logic [ENTRY_W-1:0] out_entry;
  logic [LVL_W-1:0]   level;
  logic [15:0]        drop_cnt;

  int tests = 0;
  int fails = 0;

  logic [ENTRY_W-1:0] mq[$];
  bit                 m_ovf;
  int                 m_drop;
  logic [31:0]        m_ts;

  commit_trace_buffer dut (
    .clk(clk), .reset(reset), .trace_en(trace_en), .reg_write_sig(reg_write_sig),
    .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_entry(out_entry), .level(level), .overflow(overflow), .drop_cnt(drop_cnt),
    .clear_ovf(clear_ovf)
  );

  function automatic logic [ENTRY_W-1:0] model_entry();
    logic [BASE_W-1:0] b;
    bit rev, mev;
    rev = reg_write_sig && (reg_num != 5'd0);
    mev = wr || rd;
    b = {rev, rev ? reg_num : 5'd0, rev ? reg_data : 32'd0, wr, rd,
         mev ? addr : 9'd0, wr ? wr_data : (rd ? rd_data : 32'd0)};
`ifdef TRACE_TIMESTAMP_EN
    return {m_ts, b};
`else
    return b;
`endif
  endfunction

  task automatic idle_in();
    trace_en = 1'b1; reg_write_sig = 1'b0; reg_num = 5'd0; reg_data = '0;
    wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0; clear_ovf = 1'b0;
  endtask

  task automatic store_in();
    wr = 1'b1; addr = 9'($urandom); wr_data = $urandom;
  endtask

  // One clock: model consumes the current inputs, DUT samples them, then settle.
  task automatic tick();
    bit ev, pop, full, drop;
    logic [ENTRY_W-1:0] e;
    ev   = trace_en && ((reg_write_sig && reg_num != 5'd0) || wr || rd);
    e    = model_entry();
    pop  = (mq.size() != 0) && out_ready;
    full = (mq.size() == DEPTH);
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete(); m_ovf = 0; m_drop = 0; m_ts = '0;
    end else begin
      drop = 0;
      if (pop) mq.delete(0);
      if (ev) begin
        if (!full || pop) mq.push_back(e);
        else drop = 1;
      end
      if (clear_ovf) begin
        m_ovf = 0; m_drop = 0;
      end else if (drop) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
      m_ts = m_ts + 32'd1;
    end
  endtask

  task automatic test_reset();
    idle_in(); out_ready = 1'b0; reset = 1'b1;
    tick(); tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    tests++; if (out_entry !== '0) begin fails++; $display("FAIL reset_entry: got %0h expected 0", out_entry); end
    tests++; if (level !== '0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
    tests++; if (drop_cnt !== '0) begin fails++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_single_reg();
    idle_in(); out_ready = 1'b1;
    reg_write_sig = 1'b1; reg_num = 5'd5; reg_data = 32'hDEADBEEF;
    tick(); idle_in();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b expected 1", out_valid); end
    tests++; if (level !== 5'd1) begin fails++; $display("FAIL single_level: got %0d expected 1", level); end
    tests++; if (out_entry[REG_EV_BIT] !== 1'b1 || out_entry[REG_NUM_LSB +: 5] !== 5'd5 ||
                 out_entry[REG_DATA_LSB +: 32] !== 32'hDEADBEEF || out_entry[MEM_WR_BIT] !== 1'b0 ||
                 out_entry[MEM_RD_BIT] !== 1'b0) begin
      fails++; $display("FAIL single_fields: got %0h", out_entry);
    end
    tests++; if (mq.size() != 1 || out_entry !== mq[0]) begin fails++; $display("FAIL single_entry: got %0h model size %0d", out_entry, mq.size()); end
    tick();
    tests++; if (level !== 5'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL single_pop: got level %0d valid %0b expected 0 0", level, out_valid); end
  endtask

  task automatic test_x0_combined();
    logic [BASE_W-1:0] exp_b;
    trace_base_t pk;
    idle_in(); out_ready = 1'b1;
    reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = $urandom;
    tick(); idle_in();
    tests++; if (level !== 5'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL x0_filter: got level %0d valid %0b expected 0 0", level, out_valid); end
    exp_b = {1'b1, 5'd7, 32'h1234, 1'b0, 1'b1, 9'h010, 32'h1234};
    pk = pack_entry(1'b1, 5'd7, 32'h1234, 1'b0, 1'b1, 9'h010, 32'h0, 32'h1234);
    tests++; if (pk !== exp_b) begin fails++; $display("FAIL pack_fn: got %0h expected %0h", pk, exp_b); end
    rd = 1'b1; addr = 9'h010; rd_data = 32'h1234; reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'h1234;
    tick(); idle_in();
    tests++; if (level !== 5'd1) begin fails++; $display("FAIL comb_level: got %0d expected 1", level); end
    tests++; if (out_entry[BASE_W-1:0] !== exp_b) begin fails++; $display("FAIL comb_entry: got %0h expected %0h", out_entry[BASE_W-1:0], exp_b); end
    wr = 1'b1; rd = 1'b1; addr = 9'h1A5; wr_data = 32'hCAFE0001; rd_data = 32'h0BAD0002;
    exp_b = {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 9'h1A5, 32'hCAFE0001};
    tick(); idle_in();
    tests++; if (out_entry[BASE_W-1:0] !== exp_b) begin fails++; $display("FAIL wr_rd_entry: got %0h expected %0h", out_entry[BASE_W-1:0], exp_b); end
    tick();
  endtask

  task automatic test_fill_overflow();
    logic [ENTRY_W-1:0] stored[20];
    idle_in(); reset = 1'b1; tick(); reset = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle_in(); store_in(); stored[i] = model_entry(); tick();
    end
    idle_in();
    tests++; if (level !== 5'd16) begin fails++; $display("FAIL fill_level: got %0d expected 16", level); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL fill_ovf: got %0b expected 1", overflow); end
    tests++; if (drop_cnt !== 16'd4) begin fails++; $display("FAIL fill_drop: got %0d expected 4", drop_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests++; if (out_valid !== 1'b1 || out_entry !== stored[i]) begin
        fails++; $display("FAIL drain_order[%0d]: got %0h valid %0b expected %0h", i, out_entry, out_valid, stored[i]);
      end
      tick();
    end
    tests++; if (out_valid !== 1'b0 || level !== 5'd0) begin fails++; $display("FAIL drain_empty: got valid %0b level %0d expected 0 0", out_valid, level); end
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    tests++; if (overflow !== 1'b0 || drop_cnt !== '0) begin fails++; $display("FAIL clear_idle: got ovf %0b drop %0d expected 0 0", overflow, drop_cnt); end
  endtask

  task automatic test_full_push_pop();
    idle_in(); out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin idle_in(); store_in(); tick(); end
    tests++; if (level !== 5'd16) begin fails++; $display("FAIL fpp_fill: got %0d expected 16", level); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle_in(); store_in();
      tests++; if (out_entry !== mq[0]) begin fails++; $display("FAIL fpp_head[%0d]: got %0h expected %0h", i, out_entry, mq[0]); end
      tick();
      tests++; if (level !== 5'd16 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
        fails++; $display("FAIL fpp_state[%0d]: got level %0d drop %0d ovf %0b expected 16 0 0", i, level, drop_cnt, overflow);
      end
    end
    idle_in();
    for (int i = 0; i < 16; i++) begin
      tests++; if (out_valid !== 1'b1 || out_entry !== mq[0]) begin fails++; $display("FAIL fpp_drain[%0d]: got %0h expected %0h", i, out_entry, mq[0]); end
      tick();
    end
    tests++; if (level !== 5'd0) begin fails++; $display("FAIL fpp_empty: got %0d expected 0", level); end
  endtask

  task automatic test_backpressure_clear();
    logic [ENTRY_W-1:0] prev_entry;
    bit prev_stall;
    for (int i = 0; i < 300; i++) begin
      idle_in();
      trace_en = ($urandom_range(0, 4) != 0);
      reg_write_sig = $urandom_range(0, 1); reg_num = 5'($urandom); reg_data = $urandom;
      wr = ($urandom_range(0, 2) == 0); rd = ($urandom_range(0, 2) == 0);
      addr = 9'($urandom); wr_data = $urandom; rd_data = $urandom;
      out_ready = ($urandom_range(0, 9) < 4);
      clear_ovf = ($urandom_range(0, 31) == 0);
      prev_stall = out_valid && !out_ready;
      prev_entry = out_entry;
      tick();
      if (prev_stall) begin
        tests++; if (out_entry !== prev_entry) begin fails++; $display("FAIL stall_stable[%0d]: got %0h expected %0h", i, out_entry, prev_entry); end
      end
      tests++; if (level !== LVL_W'(mq.size()) || out_valid !== (mq.size() != 0)) begin
        fails++; $display("FAIL rand_level[%0d]: got %0d valid %0b expected %0d", i, level, out_valid, mq.size());
      end
      if (mq.size() != 0) begin
        tests++; if (out_entry !== mq[0]) begin fails++; $display("FAIL rand_head[%0d]: got %0h expected %0h", i, out_entry, mq[0]); end
      end
      tests++; if (overflow !== m_ovf || drop_cnt !== 16'(m_drop)) begin
        fails++; $display("FAIL rand_ovf[%0d]: got ovf %0b drop %0d expected %0b %0d", i, overflow, drop_cnt, m_ovf, m_drop);
      end
    end
    idle_in(); out_ready = 1'b0;
    for (int i = 0; i < 40 && mq.size() < DEPTH; i++) begin idle_in(); store_in(); tick(); end
    idle_in(); store_in(); tick();
    tests++; if (overflow !== 1'b1 || drop_cnt === 16'd0) begin fails++; $display("FAIL pre_clear: got ovf %0b drop %0d expected 1 nonzero", overflow, drop_cnt); end
    idle_in(); store_in(); clear_ovf = 1'b1; tick(); idle_in();
    tests++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin fails++; $display("FAIL clear_vs_drop: got ovf %0b drop %0d expected 0 0", overflow, drop_cnt); end
    tests++; if (level !== 5'd16) begin fails++; $display("FAIL clear_level: got %0d expected 16", level); end
  endtask

  task automatic test_reset_mid_drain();
    idle_in(); reset = 1'b1; tick(); reset = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin idle_in(); store_in(); tick(); end
    idle_in(); out_ready = 1'b1; tick();
    tests++; if (level !== 5'd9) begin fails++; $display("FAIL mid_level: got %0d expected 9", level); end
    reset = 1'b1; tick(); reset = 1'b0;
    tests++; if (out_valid !== 1'b0 || level !== 5'd0) begin fails++; $display("FAIL mid_reset: got valid %0b level %0d expected 0 0", out_valid, level); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    store_in(); tick(); idle_in();
    tests++; if (level !== 5'd1 || out_entry !== mq[0]) begin fails++; $display("FAIL post_reset_entry: got %0h level %0d expected %0h", out_entry, level, mq[0]); end
`ifdef TRACE_TIMESTAMP_EN
    tests++; if (out_entry[TS_LSB +: 32] !== 32'd3) begin fails++; $display("FAIL post_reset_ts: got %0d expected 3", out_entry[TS_LSB +: 32]); end
`endif
  endtask

  initial begin
    m_ovf = 0; m_drop = 0; m_ts = '0;
    test_reset();
    test_single_reg();
    test_x0_combined();
    test_fill_overflow();
    test_full_push_pop();
    test_backpressure_clear();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
